// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU: instruction opcodes and the
// control sequencer state enumeration.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_FETCH   = 3'd1;
    localparam logic [2:0] S_DECODE  = 3'd2;
    localparam logic [2:0] S_EXEC_RD = 3'd3;
    localparam logic [2:0] S_EXEC_WR = 3'd4;
    localparam logic [2:0] S_HALT    = 3'd5;

endpackage

// File: rtl/control_sequencer.sv
// Control sequencer for a small accumulator CPU: fetch / decode / operand
// access, with every strobe decoded combinationally from the current state.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       clear_n,
    input  logic       run,
    input  logic [2:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_clear,
    output logic       pc_load,
    output logic       pc_inc,
    output logic       ir_load,
    output logic       acc_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic [2:0] state
);

    logic [2:0] state_q;
    logic [2:0] state_d;

    assign state = state_q;

    // Memory handshake: a rd/wr strobe is held until mem_ready is seen high in
    // the same cycle; that cycle completes the access and the state advances.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_clear = 1'b0;
        pc_load  = 1'b0;
        pc_inc   = 1'b0;
        ir_load  = 1'b0;
        acc_load = 1'b0;
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        alu_op   = 3'b000;
        halted   = 1'b0;
        case (state_q)
            S_IDLE: begin
                pc_clear = 1'b1;
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_rd = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                case (opcode)
                    OP_HLT: state_d = S_HALT;
                    OP_SKZ: begin
                        pc_inc  = zero;
                        state_d = S_FETCH;
                    end
                    OP_JMP: begin
                        pc_load  = 1'b1;
                        addr_sel = 1'b1;
                        state_d  = S_FETCH;
                    end
                    OP_STO:  state_d = S_EXEC_WR;
                    default: state_d = S_EXEC_RD;
                endcase
            end
            S_EXEC_RD: begin
                addr_sel = 1'b1;
                mem_rd   = 1'b1;
                alu_op   = opcode;
                if (mem_ready) begin
                    acc_load = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            S_EXEC_WR: begin
                addr_sel = 1'b1;
                mem_wr   = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_HALT:  halted  = 1'b1;
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 clear_n  input  1  asynchronous active-low reset.
REQ-004 run  input  1  level; leaves IDLE when 1.
REQ-005 opcode  input  3  instruction register bits [7:5].
REQ-006 zero  input  1  accumulator-zero flag.
REQ-007 mem_ready  input  1  memory completes the current rd/wr this cycle.
REQ-008 pc_clear, pc_load, pc_inc  output  1 each  drive the 8-bit PC register's clear/load/inc.
REQ-009 ir_load, acc_load  output  1 each  load the instruction register / accumulator.
REQ-010 mem_rd, mem_wr  output  1 each  memory read/write strobes.
REQ-011 addr_sel  output  1  0 = PC drives the address bus, 1 = IR operand [4:0].
REQ-012 alu_op  output  3  equals opcode during EXEC_RD, else 000.
REQ-013 halted  output  1  high in HALT.

Function
REQ-014 States SHALL be IDLE, FETCH, DECODE, EXEC_RD, EXEC_WR, HALT; all outputs are combinational from state, opcode, zero and mem_ready.
REQ-015 Opcodes: HLT=000, SKZ=001, ADD=010, AND=011, XOR=100, LDA=101, STO=110, JMP=111.
REQ-016 IDLE: pc_clear=1; go to FETCH when run=1, else stay.
REQ-017 FETCH: addr_sel=0, mem_rd=1; if mem_ready then ir_load=1, pc_inc=1 and go to DECODE; else stay with no other strobes.
REQ-018 DECODE, one cycle: HLT -> HALT; SKZ -> pc_inc=zero, then FETCH; JMP -> pc_load=1, addr_sel=1, then FETCH; ADD/AND/XOR/LDA -> EXEC_RD; STO -> EXEC_WR.
REQ-019 EXEC_RD: addr_sel=1, mem_rd=1; on mem_ready, acc_load=1 and go to FETCH.
REQ-020 EXEC_WR: addr_sel=1, mem_wr=1; on mem_ready, go to FETCH.
REQ-021 HALT: halted=1, all strobes 0; exit only by reset.
REQ-022 At most one of pc_clear/pc_load/pc_inc SHALL be 1 in any cycle.
REQ-023 mem_rd and mem_wr SHALL never both be 1.
REQ-024 Latency without stalls: HLT/SKZ/JMP take 2 cycles (FETCH, DECODE); memory operands take 3 cycles; each mem_ready=0 cycle adds one.
REQ-025 run is sampled only in IDLE; dropping run mid-instruction SHALL have no effect.

Reset
REQ-026 On clear_n=0 the state SHALL go to IDLE immediately, regardless of clk, and outputs become IDLE values: pc_clear=1, all others 0.
REQ-027 Reset during a stalled FETCH/EXEC_WR SHALL drop mem_rd/mem_wr in the same cycle; no acc_load or ir_load is issued.
REQ-028 After clear_n rises, the first state change SHALL occur on the next rising clk edge, subject to run.

Structure
REQ-029 The opcode encodings (REQ-015) and the state enumeration SHALL live in the shared package cpu_pkg.
REQ-030 The block SHALL be flat with no sub-module; the next-state and output decode are single case statements.

Verification
REQ-031 Reset, run=0 for 5 cycles -> stays in IDLE with pc_clear=1; run=1 -> FETCH on the next edge.
REQ-032 FETCH with mem_ready=1, opcode=ADD -> ir_load/pc_inc in the FETCH cycle, then DECODE, then EXEC_RD with alu_op=010 and acc_load=1 -> FETCH.
REQ-033 SKZ with zero=1 -> pc_inc pulses in FETCH and in DECODE (2 total); with zero=0 -> only 1.
REQ-034 STO with mem_ready held 0 for 3 cycles -> mem_wr=1 for 4 cycles and addr_sel=1 throughout, then FETCH.
REQ-035 JMP -> pc_load=1 for exactly one cycle in DECODE, then FETCH; HLT -> halted=1 persists for 20 cycles until clear_n=0.
REQ-036 Assert clear_n=0 mid EXEC_RD stall -> mem_rd=0 and pc_clear=1 immediately with no clk edge; random opcode/ready stress -> REQ-022/023 never violated.
